// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of a shared W-bit enabled register.
// Grants at most one write per cycle and enforces GAP idle cycles after each write.
module dff_write_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    parameter int unsigned GAP = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     reg_d,
    output logic             reg_en,
    output logic             busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        COOL
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ptr, ptr_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [W-1:0]   d_nxt;
    logic           busy_nxt;

    logic [N-1:0]   elig;
    logic           found;
    logic [PW-1:0]  win;
    logic [PW-1:0]  idx;

    // Rotating first-set search starting at ptr; the requester granted this cycle is masked.
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // busy is registered from the state that governed the previous decision, so it covers
    // exactly the forced-idle output cycles and never overlaps the write cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        d_nxt     = reg_d;
        busy_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt[win] = 1'b1;
                    d_nxt        = wdata[32'(win)*W +: W];
                    ptr_nxt      = (win == PW'(N - 1)) ? '0 : win + PW'(1);
                    if (GAP > 0) begin
                        state_nxt = COOL;
                        cnt_nxt   = 4'(GAP);
                    end
                end
            end
            COOL: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            gnt    <= '0;
            reg_d  <= '0;
            reg_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            gnt    <= gnt_nxt;
            reg_d  <= d_nxt;
            reg_en <= |gnt_nxt;
            busy   <= busy_nxt;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
    a_en_matches:  assert property (@(posedge clk) disable iff (!reset_n) reg_en == (|gnt));
    a_gnt_had_req: assert property (@(posedge clk) disable iff (!reset_n) (gnt & ~$past(req)) == '0);
    a_busy_no_en:  assert property (@(posedge clk) disable iff (!reset_n) busy |-> !reg_en);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: three instances (GAP 0, 2, 3) share stimulus,
// a behavioural model pushes expected outputs per edge, popped and compared after the edge.
module tb_dff_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] wdata;

    logic [3:0]  gnt_o  [3];
    logic [3:0]  d_o    [3];
    logic        en_o   [3];
    logic        busy_o [3];

    logic [3:0]  q0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] d;
        logic       en;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    int          gaps   [3];
    int          m_ptr  [3];
    int          m_hold [3];
    logic [3:0]  m_gnt  [3];
    logic [3:0]  m_d    [3];
    logic        m_busy [3];

    int n_cmp;
    int n_bad;

    dff_write_arbiter #(.N(4), .W(4), .GAP(0)) u_g0 (
        .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata),
        .gnt(gnt_o[0]), .reg_d(d_o[0]), .reg_en(en_o[0]), .busy(busy_o[0])
    );
    dff_write_arbiter #(.N(4), .W(4), .GAP(2)) u_g2 (
        .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata),
        .gnt(gnt_o[1]), .reg_d(d_o[1]), .reg_en(en_o[1]), .busy(busy_o[1])
    );
    dff_write_arbiter #(.N(4), .W(4), .GAP(3)) u_g3 (
        .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata),
        .gnt(gnt_o[2]), .reg_d(d_o[2]), .reg_en(en_o[2]), .busy(busy_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The shared register that the GAP=0 instance feeds.
    always @(posedge clk) begin
        if (en_o[0]) q0 <= d_o[0];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a hold count of remaining forced-idle edges instead of an explicit state.
    task automatic model_edge();
        logic [3:0] elig;
        int         win;
        exp_t       e;
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                m_ptr[k]  = 0;
                m_hold[k] = 0;
                m_gnt[k]  = '0;
                m_d[k]    = '0;
                m_busy[k] = 1'b0;
            end else if (m_hold[k] > 0) begin
                m_gnt[k]  = '0;
                m_busy[k] = 1'b1;
                m_hold[k] = m_hold[k] - 1;
            end else begin
                m_busy[k] = 1'b0;
                elig      = req & ~m_gnt[k];
                win       = -1;
                for (int j = 0; j < 4; j++) begin
                    if (win < 0 && elig[2'((m_ptr[k] + j) % 4)]) win = (m_ptr[k] + j) % 4;
                end
                m_gnt[k] = '0;
                if (win >= 0) begin
                    m_gnt[k][2'(win)] = 1'b1;
                    m_d[k]            = wdata[win*4 +: 4];
                    m_ptr[k]          = (win + 1) % 4;
                    m_hold[k]         = gaps[k];
                end
            end
            e.gnt  = m_gnt[k];
            e.d    = m_d[k];
            e.en   = |m_gnt[k];
            e.busy = m_busy[k];
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            check_val($sformatf("g%0d_gnt", gaps[k]),  32'(gnt_o[k]),  32'(e.gnt));
            check_val($sformatf("g%0d_d", gaps[k]),    32'(d_o[k]),    32'(e.d));
            check_val($sformatf("g%0d_en", gaps[k]),   32'(en_o[k]),   32'(e.en));
            check_val($sformatf("g%0d_busy", gaps[k]), 32'(busy_o[k]), 32'(e.busy));
        end
        @(negedge clk);
    endtask

    logic [3:0] rr_gnt [8];
    logic [3:0] g2_gnt [9];
    logic       g2_busy[9];

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        gaps    = '{0, 2, 3};
        rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        g2_gnt  = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        g2_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reset_n = 1'b0;
        req     = 4'b1111;
        wdata   = 16'h4321;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            m_ptr[k] = 0; m_hold[k] = 0; m_gnt[k] = '0; m_d[k] = '0; m_busy[k] = 1'b0;
        end

        // Reset held with all requests asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("rst_gnt",  32'(gnt_o[0]),  32'h0);
            check_val("rst_d",    32'(d_o[0]),    32'h0);
            check_val("rst_en",   32'(en_o[0]),   32'h0);
            check_val("rst_busy", 32'(busy_o[2]), 32'h0);
        end

        // Round-robin with all four requesting, GAP=0.
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("rr_gnt", 32'(gnt_o[0]), 32'(rr_gnt[i]));
            check_val("rr_d",   32'(d_o[0]),   32'((i % 4) + 1));
        end

        // All idle: no grant and reg_d holds its last value.
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("idle_en", 32'(en_o[0]), 32'h0);
            check_val("idle_d",  32'(d_o[0]),  32'h4);
        end

        // Single requester 2 with data A, dropped after its grant.
        wdata = 16'h4A21;
        req   = 4'b0100;
        step();
        check_val("single_gnt", 32'(gnt_o[0]), 32'b0100);
        check_val("single_d",   32'(d_o[0]),   32'hA);
        req = 4'b0000;
        step();
        check_val("single_drop_en", 32'(en_o[0]), 32'h0);
        check_val("single_q",       32'(q0),      32'hA);

        // Move ptr to 2, then requests below the pointer must be found by wrap-around.
        req = 4'b0010;
        step();
        req = 4'b0011;
        step();
        check_val("skip_gnt0", 32'(gnt_o[0]), 32'b0001);
        step();
        check_val("skip_gnt1", 32'(gnt_o[0]), 32'b0010);
        req = 4'b1111;
        step();
        check_val("skip_ptr2", 32'(gnt_o[0]), 32'b0100);

        // GAP=2 with two requesters from a clean start.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req     = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            step();
            check_val("gap2_gnt",  32'(gnt_o[1]),  32'(g2_gnt[i]));
            check_val("gap2_en",   32'(en_o[1]),   32'(|g2_gnt[i]));
            check_val("gap2_busy", 32'(busy_o[1]), 32'(g2_busy[i]));
        end

        // Reset one cycle into the GAP=3 cooldown.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check_val("cool_first_gnt", 32'(gnt_o[2]), 32'b0001);
        step();
        check_val("cool_busy", 32'(busy_o[2]), 32'h1);
        reset_n = 1'b0;
        step();
        check_val("cool_rst_busy", 32'(busy_o[2]), 32'h0);
        check_val("cool_rst_gnt",  32'(gnt_o[2]),  32'h0);
        reset_n = 1'b1;
        step();
        check_val("cool_restart_gnt", 32'(gnt_o[2]), 32'b0001);

        // Random requests with occasional reset.
        wdata = 16'h9C5E;
        for (int i = 0; i < 80; i++) begin
            req     = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 19) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
